// File: rtl/flash_pkg.sv
// flash_pkg: shared widths, types and helpers for the flash read responder.
//   flash_word_t : one 32-bit flash data word
//   flash_addr_t : one 23-bit flash word address
//   rd_stage_t   : one read-latency pipeline slot {valid, oob, data}
package flash_pkg;

    localparam int FLASH_ADDR_W = 23;
    localparam int FLASH_DATA_W = 32;
    localparam int ROM_ADDR_W   = 15;

    typedef logic [FLASH_DATA_W-1:0] flash_word_t;
    typedef logic [FLASH_ADDR_W-1:0] flash_addr_t;

    typedef struct packed {
        logic        valid;
        logic        oob;
        flash_word_t data;
    } rd_stage_t;

    localparam int STAGE_W = $bits(rd_stage_t);

    // Bounds are passed one bit wider than the address so that BASE+MAX_OFFSET
    // cannot wrap when it sits at the very top of the address space.
    function automatic logic addr_out_of_range(input flash_addr_t addr,
                                               input logic [23:0] base,
                                               input logic [23:0] last);
        logic [23:0] ext;
        ext = {1'b0, addr};
        return (ext < base) || (ext > last);
    endfunction

endpackage

// File: rtl/flash_latency_pipe.sv
// flash_latency_pipe: fixed-depth shift register of read slots.
//   clk_i   : clock
//   clear_i : synchronous clear, drops every slot and zeroes its data
//   stage_i : slot entering the first stage (packed rd_stage_t)
//   valid_o : last stage valid
//   data_o  : last stage data, holds the last valid word between returns
module flash_latency_pipe
    import flash_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               clear_i,
    input  logic [STAGE_W-1:0] stage_i,
    output logic               valid_o,
    output logic [31:0]        data_o
);

    rd_stage_t stage_in_s;
    rd_stage_t stage_q [DEPTH];

    assign stage_in_s = rd_stage_t'(stage_i);

    // Shift slots forward; payload only moves with a valid slot, so the last
    // stage keeps the most recently returned word while idle.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0].valid <= stage_in_s.valid;
            if (stage_in_s.valid) begin
                stage_q[0].oob  <= stage_in_s.oob;
                // Out-of-range reads return zero no matter what the ROM drove.
                stage_q[0].data <= stage_in_s.oob ? 32'h0000_0000 : stage_in_s.data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i].valid <= stage_q[i-1].valid;
                if (stage_q[i-1].valid) begin
                    stage_q[i].oob  <= stage_q[i-1].oob;
                    stage_q[i].data <= stage_q[i-1].data;
                end
            end
        end
    end

    assign valid_o = stage_q[DEPTH-1].valid;
    assign data_o  = stage_q[DEPTH-1].data;

endmodule

// File: rtl/flash_mem_responder.sv
// flash_mem_responder: Avalon-MM pipelined read slave backed by a ROM port.
//   fetch_clock             : clock
//   reset                   : synchronous active-high reset
//   flash_mem_read          : read request
//   flash_mem_address       : word address
//   stall_inject            : forces waitrequest high
//   flash_mem_waitrequest   : request not accepted this cycle
//   flash_mem_readdata      : returned word
//   flash_mem_readdatavalid : readdata valid this cycle
//   rom_address             : registered ROM word address
//   rom_q                   : ROM data for rom_address, sampled one cycle later
//   range_error             : sticky out-of-range accept flag
module flash_mem_responder
    import flash_pkg::*;
#(
    parameter int BASE         = 0,
    parameter int MAX_OFFSET   = 16'h7FFF,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 4
) (
    input  logic        fetch_clock,
    input  logic        reset,
    input  logic        flash_mem_read,
    input  logic [22:0] flash_mem_address,
    input  logic        stall_inject,
    output logic        flash_mem_waitrequest,
    output logic [31:0] flash_mem_readdata,
    output logic        flash_mem_readdatavalid,
    output logic [14:0] rom_address,
    input  logic [31:0] rom_q,
    output logic        range_error
);

    localparam logic [23:0] BASE_W     = 24'(BASE);
    localparam logic [23:0] LAST_W     = 24'(BASE + MAX_OFFSET);
    localparam logic [3:0]  MAX_PEND_W = 4'(MAX_PENDING);
    localparam logic [14:0] BASE_LOW_W = 15'(BASE);

    logic        waitrequest_s;
    logic        accept_s;
    logic        oob_s;
    logic [14:0] rom_off_s;
    logic [3:0]  pending_q;
    logic [3:0]  pending_d;
    logic        req_valid_q;
    logic        req_oob_q;
    logic [14:0] rom_address_q;
    logic        range_error_q;
    rd_stage_t   stage1_s;

    // A return in this cycle does not open a slot until the next cycle.
    assign waitrequest_s = reset | stall_inject | (pending_q == MAX_PEND_W);
    assign accept_s      = flash_mem_read & ~waitrequest_s;
    assign oob_s         = addr_out_of_range(flash_mem_address, BASE_W, LAST_W);
    // Subtraction modulo 2^15 equals the low 15 bits of (address - BASE).
    assign rom_off_s     = flash_mem_address[14:0] - BASE_LOW_W;

    // Outstanding-read count: +1 per accept, -1 per return.
    always_comb begin
        pending_d = pending_q;
        case ({accept_s, flash_mem_readdatavalid})
            2'b10:   pending_d = pending_q + 4'd1;
            2'b01:   pending_d = pending_q - 4'd1;
            default: pending_d = pending_q;
        endcase
    end

    // Request capture: ROM address, in-flight tag and sticky range flag.
    always_ff @(posedge fetch_clock) begin
        if (reset) begin
            pending_q     <= 4'd0;
            req_valid_q   <= 1'b0;
            req_oob_q     <= 1'b0;
            rom_address_q <= 15'd0;
            range_error_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            req_valid_q <= accept_s;
            if (accept_s) begin
                req_oob_q     <= oob_s;
                rom_address_q <= rom_off_s;
            end
            if (accept_s && oob_s) begin
                range_error_q <= 1'b1;
            end
        end
    end

    // The ROM word for the request issued last cycle joins its tag here.
    always_comb begin
        stage1_s       = '0;
        stage1_s.valid = req_valid_q;
        stage1_s.oob   = req_oob_q;
        stage1_s.data  = rom_q;
    end

    // Stage 1 lands one edge after accept, the last stage READ_LATENCY-1 edges after.
    flash_latency_pipe #(
        .DEPTH (READ_LATENCY - 1)
    ) u_pipe (
        .clk_i   (fetch_clock),
        .clear_i (reset),
        .stage_i (stage1_s),
        .valid_o (flash_mem_readdatavalid),
        .data_o  (flash_mem_readdata)
    );

    assign flash_mem_waitrequest = waitrequest_s;
    assign rom_address           = rom_address_q;
    assign range_error           = range_error_q;

endmodule

// File: tb/tb_flash_mem_responder.sv
// Directed bench for flash_mem_responder: default instance plus a
// MAX_PENDING=2 / READ_LATENCY=4 instance, each with a combinational ROM model.
module tb_flash_mem_responder;

    logic        clk;
    logic        rst;

    logic        rd_a, stall_a, wait_a, rdv_a, rerr_a;
    logic [22:0] addr_a;
    logic [31:0] rdata_a, rom_q_a;
    logic [14:0] rom_addr_a;

    logic        rd_b, stall_b, wait_b, rdv_b, rerr_b;
    logic [22:0] addr_b;
    logic [31:0] rdata_b, rom_q_b;
    logic [14:0] rom_addr_b;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rom_word(input logic [14:0] a);
        if (a == 15'h0010) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + {17'd0, a};
    endfunction

    assign rom_q_a = rom_word(rom_addr_a);
    assign rom_q_b = rom_word(rom_addr_b);

    flash_mem_responder dut_a (
        .fetch_clock(clk), .reset(rst), .flash_mem_read(rd_a), .flash_mem_address(addr_a),
        .stall_inject(stall_a), .flash_mem_waitrequest(wait_a), .flash_mem_readdata(rdata_a),
        .flash_mem_readdatavalid(rdv_a), .rom_address(rom_addr_a), .rom_q(rom_q_a),
        .range_error(rerr_a)
    );

    flash_mem_responder #(.MAX_PENDING(2), .READ_LATENCY(4)) dut_b (
        .fetch_clock(clk), .reset(rst), .flash_mem_read(rd_b), .flash_mem_address(addr_b),
        .stall_inject(stall_b), .flash_mem_waitrequest(wait_b), .flash_mem_readdata(rdata_b),
        .flash_mem_readdatavalid(rdv_b), .rom_address(rom_addr_b), .rom_q(rom_q_b),
        .range_error(rerr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        checks++; if (rdv_a !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b want 0", rdv_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_a); end
        checks++; if (rom_addr_a !== 15'h0) begin errors++; $display("FAIL reset_romaddr got %h want 0", rom_addr_a); end
        checks++; if (rerr_a !== 1'b0) begin errors++; $display("FAIL reset_rerr got %b want 0", rerr_a); end
        checks++; if (wait_a !== 1'b1) begin errors++; $display("FAIL reset_wait got %b want 1", wait_a); end
        checks++; if (dut_a.pending_q !== 4'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", dut_a.pending_q); end
        rst = 1'b0;
        #1;
        checks++; if (wait_a !== 1'b0) begin errors++; $display("FAIL reset_release_wait got %b want 0", wait_a); end
        tick();
    endtask

    task automatic test_single();
        rd_a = 1'b1; addr_a = 23'h000010;
        #1;
        checks++; if (wait_a !== 1'b0) begin errors++; $display("FAIL single_wait_pre got %b want 0", wait_a); end
        tick();
        rd_a = 1'b0;
        checks++; if (rom_addr_a !== 15'h0010) begin errors++; $display("FAIL single_romaddr got %h want 0010", rom_addr_a); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rdv_a !== (k == 2)) begin errors++; $display("FAIL single_rdv k=%0d got %b want %b", k, rdv_a, (k == 2)); end
            checks++;
            if (wait_a !== 1'b0) begin errors++; $display("FAIL single_wait k=%0d got %b want 0", k, wait_a); end
            if (k >= 2) begin
                checks++;
                if (rdata_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata k=%0d got %h want deadbeef", k, rdata_a); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int pend_exp, acc, ret;
        for (int c = 0; c < 13; c++) begin
            rd_a = (c < 8); addr_a = 23'(c);
            #1;
            if (c < 8) begin
                checks++;
                if (wait_a !== 1'b0) begin errors++; $display("FAIL b2b_wait c=%0d got %b want 0", c, wait_a); end
            end
            tick();
            checks++;
            if (rdv_a !== (c >= 2 && c < 10)) begin errors++; $display("FAIL b2b_rdv c=%0d got %b want %b", c, rdv_a, (c >= 2 && c < 10)); end
            if (c >= 2 && c < 10) begin
                checks++;
                if (rdata_a !== 32'h1000_0000 + 32'(c - 2)) begin errors++; $display("FAIL b2b_rdata c=%0d got %h want %h", c, rdata_a, 32'h1000_0000 + 32'(c - 2)); end
            end
            acc = (c + 1 < 8) ? c + 1 : 8;
            ret = (c - 2 < 0) ? 0 : ((c - 2 > 8) ? 8 : c - 2);
            pend_exp = acc - ret;
            checks++;
            if (dut_a.pending_q !== 4'(pend_exp)) begin errors++; $display("FAIL b2b_pending c=%0d got %0d want %0d", c, dut_a.pending_q, pend_exp); end
        end
        rd_a = 1'b0;
    endtask

    task automatic test_pending_limit();
        logic [9:0] wait_exp;
        logic [9:0] rdv_exp;
        logic       acc;
        int         n_acc, n_ret;
        // bit c = expected value in cycle c (before edge c) / after edge c
        wait_exp = 10'b11_1001_1100;
        rdv_exp  = 10'b11_0001_1000;
        n_acc = 0; n_ret = 0;
        for (int c = 0; c < 10; c++) begin
            rd_b = 1'b1; addr_b = 23'(n_acc);
            #1;
            checks++;
            if (wait_b !== wait_exp[c]) begin errors++; $display("FAIL plim_wait c=%0d got %b want %b", c, wait_b, wait_exp[c]); end
            acc = rd_b & ~wait_b;
            tick();
            if (acc) n_acc++;
            checks++;
            if (rdv_b !== rdv_exp[c]) begin errors++; $display("FAIL plim_rdv c=%0d got %b want %b", c, rdv_b, rdv_exp[c]); end
            if (rdv_exp[c]) begin
                checks++;
                if (rdata_b !== 32'h1000_0000 + 32'(n_ret)) begin errors++; $display("FAIL plim_rdata c=%0d got %h want %h", c, rdata_b, 32'h1000_0000 + 32'(n_ret)); end
                n_ret++;
            end
            checks++;
            if (dut_b.pending_q > 4'd2) begin errors++; $display("FAIL plim_pending c=%0d got %0d want <=2", c, dut_b.pending_q); end
        end
        rd_b = 1'b0;
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_stall();
        rd_a = 1'b1; addr_a = 23'h000004; stall_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (wait_a !== 1'b1) begin errors++; $display("FAIL stall_wait k=%0d got %b want 1", k, wait_a); end
            tick();
            checks++;
            if (dut_a.pending_q !== 4'd0) begin errors++; $display("FAIL stall_pending k=%0d got %0d want 0", k, dut_a.pending_q); end
        end
        stall_a = 1'b0;
        #1;
        checks++; if (wait_a !== 1'b0) begin errors++; $display("FAIL stall_release_wait got %b want 0", wait_a); end
        tick();
        checks++; if (rom_addr_a !== 15'h0004) begin errors++; $display("FAIL stall_romaddr got %h want 0004", rom_addr_a); end
        // second read accepted, then stall re-asserted while both are in flight
        addr_a = 23'h000005;
        tick();
        rd_a = 1'b0; stall_a = 1'b1;
        tick();
        checks++; if (rdv_a !== 1'b1 || rdata_a !== 32'h1000_0004) begin errors++; $display("FAIL stall_ret0 got %b/%h want 1/10000004", rdv_a, rdata_a); end
        tick();
        checks++; if (rdv_a !== 1'b1 || rdata_a !== 32'h1000_0005) begin errors++; $display("FAIL stall_ret1 got %b/%h want 1/10000005", rdv_a, rdata_a); end
        tick();
        checks++; if (rdv_a !== 1'b0) begin errors++; $display("FAIL stall_idle got %b want 0", rdv_a); end
        stall_a = 1'b0;
        tick();
    endtask

    task automatic test_range();
        rd_a = 1'b1; addr_a = 23'h008000;
        tick();
        rd_a = 1'b0;
        checks++; if (rerr_a !== 1'b1) begin errors++; $display("FAIL range_flag_accept got %b want 1", rerr_a); end
        tick();
        checks++; if (rdv_a !== 1'b0) begin errors++; $display("FAIL range_rdv_early got %b want 0", rdv_a); end
        tick();
        checks++; if (rdv_a !== 1'b1 || rdata_a !== 32'h0) begin errors++; $display("FAIL range_ret got %b/%h want 1/00000000", rdv_a, rdata_a); end
        for (int c = 0; c < 20; c++) begin
            rd_a = 1'b1; addr_a = 23'(c);
            tick();
        end
        rd_a = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++; if (rerr_a !== 1'b1) begin errors++; $display("FAIL range_sticky got %b want 1", rerr_a); end
        checks++; if (rdv_a !== 1'b0 || rdata_a !== 32'h1000_0013) begin errors++; $display("FAIL range_hold got %b/%h want 0/10000013", rdv_a, rdata_a); end
    endtask

    task automatic test_reset_mid();
        rd_a = 1'b1; addr_a = 23'h000001;
        tick();
        addr_a = 23'h000002;
        tick();
        checks++; if (rdv_a !== 1'b0) begin errors++; $display("FAIL rmid_rdv_pre got %b want 0", rdv_a); end
        addr_a = 23'h000003; rst = 1'b1;
        #1;
        checks++; if (wait_a !== 1'b1) begin errors++; $display("FAIL rmid_wait_rst got %b want 1", wait_a); end
        tick();
        rst = 1'b0; rd_a = 1'b0;
        checks++; if (dut_a.pending_q !== 4'd0) begin errors++; $display("FAIL rmid_pending got %0d want 0", dut_a.pending_q); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL rmid_rdata got %h want 0", rdata_a); end
        checks++; if (rerr_a !== 1'b0) begin errors++; $display("FAIL rmid_rerr got %b want 0", rerr_a); end
        #1;
        checks++; if (wait_a !== 1'b0) begin errors++; $display("FAIL rmid_wait_after got %b want 0", wait_a); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (rdv_a !== 1'b0) begin errors++; $display("FAIL rmid_rdv k=%0d got %b want 0", k, rdv_a); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_a = 1'b0; addr_a = 23'h0; stall_a = 1'b0;
        rd_b = 1'b0; addr_b = 23'h0; stall_b = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_pending_limit();
        test_stall();
        test_range();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
